// File: rtl/serv_dbus_ctrl.sv
// serv_dbus_ctrl
// Data-bus controller placed after the serial buffer register. It collects
// bit-serial store data, runs one Wishbone classic cycle per request, and
// returns load data bit-serially. Load data is lane-aligned and sign- or
// zero-extended.
//
// Parameters
//   W           bits per serial cycle (1 or 4), equal to the core's BITS_PER_CYCLE
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_req       start request, sampled only while idle
//   i_we        1 = store, 0 = load
//   i_size      00 byte, 01 half, 10/11 word
//   i_signed    sign-extend the load result
//   i_adr       word address (bits [1:0] ignored)
//   i_lsb       byte offset within the word
//   i_wdat_en   shift in one store-data chunk
//   i_wdat      store data chunk, LSB first
//   i_rdat_en   shift out one load-data chunk
//   o_rdat      load data chunk, LSB first (0 when not enabled)
//   o_busy      a bus cycle is in progress
//   o_done      single-cycle pulse when the bus cycle completes
//   o_misalign  single-cycle pulse when a request is rejected
//   o_wb_*      Wishbone classic master signals
//   i_wb_rdt    Wishbone read data
//   i_wb_ack    Wishbone acknowledge
module serv_dbus_ctrl #(
  parameter int W = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [1:0]    i_size,
  input  logic          i_signed,
  input  logic [31:0]   i_adr,
  input  logic [1:0]    i_lsb,
  input  logic          i_wdat_en,
  input  logic [W-1:0]  i_wdat,
  input  logic          i_rdat_en,
  output logic [W-1:0]  o_rdat,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_misalign,
  output logic [31:0]   o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  // Byte enables for a given access size and byte offset.
  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lsb);
    logic [3:0] sel;
    case (size)
      2'b00:   sel = 4'b0001 << lsb;
      2'b01:   sel = lsb[1] ? 4'b1100 : 4'b0011;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // Store data replicated across all lanes so any selected lane carries it.
  function automatic logic [31:0] lane_dat(input logic [1:0] size, input logic [31:0] wdat);
    logic [31:0] dat;
    case (size)
      2'b00:   dat = {4{wdat[7:0]}};
      2'b01:   dat = {2{wdat[15:0]}};
      default: dat = wdat;
    endcase
    return dat;
  endfunction

  // Half-words need an even offset, words need offset zero.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = lsb[0];
      default: mis = (lsb != 2'b00);
    endcase
    return mis;
  endfunction

  state_t       state_r, state_s;
  logic         cyc_r, cyc_s;
  logic         we_r, we_s;
  logic [3:0]   sel_r, sel_s;
  logic [31:0]  dat_r, dat_s;
  logic [29:0]  adr_r, adr_s;
  logic [1:0]   size_r, size_s;
  logic         signed_r, signed_s;
  logic [1:0]   lsb_r, lsb_s;
  logic         busy_r, busy_s;
  logic         done_r, done_s;
  logic         misalign_r, misalign_s;
  logic         capture_s;

  logic [31:0]  wdat_r;
  logic [31:0]  rdat_r;
  logic         sgn_r;
  logic [4:0]   cnt_r;

  logic [31:0]  rdt_shift_s;
  logic         rdt_sign_s;
  logic [5:0]   lim_s;
  logic         rd_shift_s;
  logic [W-1:0] rdat_out_s;
  logic         unused_adr_s;

  // The two low address bits are always zero upstream and never used.
  assign unused_adr_s = ^i_adr[1:0];

  // Next-state and bus-output logic of the request/bus-cycle FSM.
  always_comb begin
    state_s    = state_r;
    cyc_s      = cyc_r;
    we_s       = we_r;
    sel_s      = sel_r;
    dat_s      = dat_r;
    adr_s      = adr_r;
    size_s     = size_r;
    signed_s   = signed_r;
    lsb_s      = lsb_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    misalign_s = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_req) begin
          if (is_misaligned(i_size, i_lsb)) begin
            misalign_s = 1'b1;
          end else begin
            state_s  = ST_BUS;
            cyc_s    = 1'b1;
            busy_s   = 1'b1;
            we_s     = i_we;
            sel_s    = lane_sel(i_size, i_lsb);
            dat_s    = lane_dat(i_size, wdat_r);
            adr_s    = i_adr[31:2];
            size_s   = i_size;
            signed_s = i_signed;
            lsb_s    = i_lsb;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (i_wb_ack) begin
          state_s   = ST_IDLE;
          cyc_s     = 1'b0;
          we_s      = 1'b0;
          sel_s     = 4'b0000;
          busy_s    = 1'b0;
          done_s    = 1'b1;
          capture_s = ~we_r;
        end else begin
          state_s = ST_BUS;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cyc_s   = 1'b0;
        we_s    = 1'b0;
        sel_s   = 4'b0000;
        busy_s  = 1'b0;
      end
    endcase
  end

  // FSM state and registered bus outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      cyc_r      <= 1'b0;
      we_r       <= 1'b0;
      sel_r      <= 4'b0000;
      dat_r      <= 32'h0000_0000;
      adr_r      <= 30'd0;
      size_r     <= 2'b00;
      signed_r   <= 1'b0;
      lsb_r      <= 2'b00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cyc_r      <= cyc_s;
      we_r       <= we_s;
      sel_r      <= sel_s;
      dat_r      <= dat_s;
      adr_r      <= adr_s;
      size_r     <= size_s;
      signed_r   <= signed_s;
      lsb_r      <= lsb_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      misalign_r <= misalign_s;
    end
  end

  // Store-data shift register, filled LSB first one chunk at a time.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdat_r <= 32'h0000_0000;
    end else if (i_wdat_en) begin
      wdat_r <= {i_wdat, wdat_r[31:W]};
    end else begin
      wdat_r <= wdat_r;
    end
  end

  // Read data aligned to bit 0 and the sign bit of the addressed item.
  always_comb begin
    rdt_shift_s = i_wb_rdt >> {lsb_r, 3'b000};
    case (size_r)
      2'b00:   rdt_sign_s = signed_r & rdt_shift_s[7];
      2'b01:   rdt_sign_s = signed_r & rdt_shift_s[15];
      default: rdt_sign_s = 1'b0;
    endcase
  end

  // Read-out only advances while idle; requests in flight ignore i_rdat_en.
  assign rd_shift_s = i_rdat_en & (state_r == ST_IDLE);

  // Load data register, sign bit and read-out bit counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdat_r <= 32'h0000_0000;
      sgn_r  <= 1'b0;
      cnt_r  <= 5'd0;
    end else if (capture_s) begin
      rdat_r <= rdt_shift_s;
      sgn_r  <= rdt_sign_s;
      cnt_r  <= 5'd0;
    end else if (rd_shift_s) begin
      rdat_r <= rdat_r >> W;
      cnt_r  <= cnt_r + 5'(W);
    end else begin
      rdat_r <= rdat_r;
      cnt_r  <= cnt_r;
    end
  end

  // Bits beyond the item width are replaced by the extension bit.
  always_comb begin
    case (size_r)
      2'b00:   lim_s = 6'd8;
      2'b01:   lim_s = 6'd16;
      default: lim_s = 6'd32;
    endcase
    rdat_out_s = '0;
    if (rd_shift_s) begin
      for (int k = 0; k < W; k++) begin
        rdat_out_s[k] = (({1'b0, cnt_r} + 6'(k)) < lim_s) ? rdat_r[k] : sgn_r;
      end
    end else begin
      rdat_out_s = '0;
    end
  end

  assign o_rdat     = rdat_out_s;
  assign o_busy     = busy_r;
  assign o_done     = done_r;
  assign o_misalign = misalign_r;
  assign o_wb_adr   = {adr_r, 2'b00};
  assign o_wb_dat   = dat_r;
  assign o_wb_sel   = sel_r;
  assign o_wb_we    = we_r;
  assign o_wb_cyc   = cyc_r;

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
module tb_serv_dbus_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req, we, sgn;
  logic [1:0]  size, lsb;
  logic [31:0] adr, wb_rdt;
  logic        ack_man, ack_auto, wb_ack;
  logic        wen1, wdat1, ren1, rdat1;
  logic        wen4, ren4;
  logic [3:0]  wdat4, rdat4;

  logic        busy1, done1, mis1, we1, cyc1;
  logic [31:0] wadr1, wdat_o1;
  logic [3:0]  sel1;
  logic        busy4, done4, mis4, we4, cyc4;
  logic [31:0] wadr4, wdat_o4;
  logic [3:0]  sel4;

  int tests = 0;
  int fails = 0;

  // Slave model: either acknowledges on the first cycle of every cycle or is driven by hand.
  assign wb_ack = ack_auto ? cyc1 : ack_man;

  serv_dbus_ctrl #(.W(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
    .i_signed(sgn), .i_adr(adr), .i_lsb(lsb), .i_wdat_en(wen1), .i_wdat(wdat1),
    .i_rdat_en(ren1), .o_rdat(rdat1), .o_busy(busy1), .o_done(done1),
    .o_misalign(mis1), .o_wb_adr(wadr1), .o_wb_dat(wdat_o1), .o_wb_sel(sel1),
    .o_wb_we(we1), .o_wb_cyc(cyc1), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack)
  );

  serv_dbus_ctrl #(.W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
    .i_signed(sgn), .i_adr(adr), .i_lsb(lsb), .i_wdat_en(wen4), .i_wdat(wdat4),
    .i_rdat_en(ren4), .o_rdat(rdat4), .o_busy(busy4), .o_done(done4),
    .o_misalign(mis4), .o_wb_adr(wadr4), .o_wb_dat(wdat_o4), .o_wb_sel(sel4),
    .o_wb_we(we4), .o_wb_cyc(cyc4), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_in(input logic [31:0] d);
    for (int i = 0; i < 32; i++) begin
      wdat1 = d[i]; wen1 = 1'b1; tick();
    end
    wen1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wdat4 = d[4*i +: 4]; wen4 = 1'b1; tick();
    end
    wen4 = 1'b0;
  endtask

  task automatic read_out(output logic [31:0] v1, output logic [31:0] v4);
    ren1 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1 v1[i] = rdat1; tick();
    end
    ren1 = 1'b0;
    ren4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 v4[4*i +: 4] = rdat4; tick();
    end
    ren4 = 1'b0;
  endtask

  task automatic start_req(input logic w, input logic [1:0] sz, input logic s,
                           input logic [1:0] l, input logic [31:0] a);
    req = 1'b1; we = w; size = sz; sgn = s; lsb = l; adr = a;
    tick();
    req = 1'b0;
  endtask

  task automatic pulse_ack();
    ack_man = 1'b1; tick(); ack_man = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++; if (cyc1 !== 1'b0 || cyc4 !== 1'b0) begin fails++; $display("FAIL reset_cyc: got %b/%b want 0", cyc1, cyc4); end
    tests++; if (busy1 !== 1'b0 || done1 !== 1'b0 || mis1 !== 1'b0) begin fails++; $display("FAIL reset_flags: busy %b done %b mis %b want 0", busy1, done1, mis1); end
    tests++; if (sel1 !== 4'h0 || we1 !== 1'b0) begin fails++; $display("FAIL reset_sel_we: sel %h we %b want 0", sel1, we1); end
    tests++; if (wadr1 !== 32'h0 || wdat_o1 !== 32'h0) begin fails++; $display("FAIL reset_adr_dat: adr %h dat %h want 0", wadr1, wdat_o1); end
    rst_n = 1'b1;
    tick();
    tests++; if (busy1 !== 1'b0 || cyc1 !== 1'b0) begin fails++; $display("FAIL reset_release: busy %b cyc %b want 0", busy1, cyc1); end
  endtask

  task automatic test_word_store();
    shift_in(32'hDEAD_BEEF);
    start_req(1'b1, 2'b10, 1'b0, 2'b00, 32'h1000_0007);
    tests++; if (sel1 !== 4'hF || sel4 !== 4'hF) begin fails++; $display("FAIL wstore_sel: got %h/%h want f", sel1, sel4); end
    tests++; if (wdat_o1 !== 32'hDEAD_BEEF || wdat_o4 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wstore_dat: got %h/%h want deadbeef", wdat_o1, wdat_o4); end
    tests++; if (wadr1 !== 32'h1000_0004 || we1 !== 1'b1 || busy1 !== 1'b1) begin fails++; $display("FAIL wstore_adr_we: adr %h we %b busy %b want 10000004 1 1", wadr1, we1, busy1); end
    for (int c = 0; c < 3; c++) begin
      tests++; if (cyc1 !== 1'b1 || done1 !== 1'b0) begin fails++; $display("FAIL wstore_cyc%0d: cyc %b done %b want 1 0", c, cyc1, done1); end
      if (c == 2) ack_man = 1'b1;
      tick();
    end
    ack_man = 1'b0;
    tests++; if (cyc1 !== 1'b0 || done1 !== 1'b1 || done4 !== 1'b1) begin fails++; $display("FAIL wstore_done: cyc %b done %b/%b want 0 1 1", cyc1, done1, done4); end
    tests++; if (sel1 !== 4'h0 || we1 !== 1'b0 || busy1 !== 1'b0) begin fails++; $display("FAIL wstore_idle: sel %h we %b busy %b want 0", sel1, we1, busy1); end
    tick();
    tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL wstore_done_pulse: got %b want 0", done1); end
  endtask

  task automatic test_byte_store();
    shift_in(32'h1234_56A5);
    start_req(1'b1, 2'b00, 1'b0, 2'b10, 32'h0000_0100);
    tests++; if (sel1 !== 4'b0100 || sel4 !== 4'b0100) begin fails++; $display("FAIL bstore_sel: got %b/%b want 0100", sel1, sel4); end
    tests++; if (wdat_o1 !== 32'hA5A5_A5A5 || wdat_o4 !== 32'hA5A5_A5A5) begin fails++; $display("FAIL bstore_dat: got %h/%h want a5a5a5a5", wdat_o1, wdat_o4); end
    tests++; if (we1 !== 1'b1) begin fails++; $display("FAIL bstore_we: got %b want 1", we1); end
    pulse_ack();
    tests++; if (done1 !== 1'b1) begin fails++; $display("FAIL bstore_done: got %b want 1", done1); end
    tick();
  endtask

  task automatic test_loads();
    logic [31:0] v1, v4;
    wb_rdt = 32'h8012_3456;
    start_req(1'b0, 2'b00, 1'b1, 2'b11, 32'h2000_0000);
    tests++; if (sel1 !== 4'b1000 || we1 !== 1'b0 || cyc1 !== 1'b1) begin fails++; $display("FAIL sbload_bus: sel %b we %b cyc %b want 1000 0 1", sel1, we1, cyc1); end
    pulse_ack();
    tests++; if (done1 !== 1'b1) begin fails++; $display("FAIL sbload_done: got %b want 1", done1); end
    read_out(v1, v4);
    tests++; if (v1 !== 32'hFFFF_FF80 || v4 !== 32'hFFFF_FF80) begin fails++; $display("FAIL sbload_data: got %h/%h want ffffff80", v1, v4); end

    start_req(1'b0, 2'b00, 1'b0, 2'b11, 32'h2000_0000);
    pulse_ack();
    read_out(v1, v4);
    tests++; if (v1 !== 32'h0000_0080 || v4 !== 32'h0000_0080) begin fails++; $display("FAIL ubload_data: got %h/%h want 00000080", v1, v4); end

    wb_rdt = 32'h7FFF_0000;
    start_req(1'b0, 2'b01, 1'b1, 2'b10, 32'h2000_0000);
    tests++; if (sel1 !== 4'b1100) begin fails++; $display("FAIL shload_sel: got %b want 1100", sel1); end
    pulse_ack();
    read_out(v1, v4);
    tests++; if (v1 !== 32'h0000_7FFF || v4 !== 32'h0000_7FFF) begin fails++; $display("FAIL shload_pos: got %h/%h want 00007fff", v1, v4); end

    wb_rdt = 32'h1234_8001;
    start_req(1'b0, 2'b01, 1'b1, 2'b00, 32'h2000_0000);
    pulse_ack();
    read_out(v1, v4);
    tests++; if (v1 !== 32'hFFFF_8001 || v4 !== 32'hFFFF_8001) begin fails++; $display("FAIL shload_neg: got %h/%h want ffff8001", v1, v4); end

    wb_rdt = 32'hCAFE_F00D;
    start_req(1'b0, 2'b11, 1'b1, 2'b00, 32'h2000_0000);
    tests++; if (sel1 !== 4'hF) begin fails++; $display("FAIL wload_sel: got %h want f", sel1); end
    pulse_ack();
    read_out(v1, v4);
    tests++; if (v1 !== 32'hCAFE_F00D || v4 !== 32'hCAFE_F00D) begin fails++; $display("FAIL wload_data: got %h/%h want cafef00d", v1, v4); end
  endtask

  task automatic test_misalign();
    start_req(1'b0, 2'b01, 1'b1, 2'b01, 32'h3000_0000);
    tests++; if (mis1 !== 1'b1 || mis4 !== 1'b1) begin fails++; $display("FAIL mis_half_pulse: got %b/%b want 1", mis1, mis4); end
    tests++; if (cyc1 !== 1'b0 || busy1 !== 1'b0) begin fails++; $display("FAIL mis_half_nocyc: cyc %b busy %b want 0", cyc1, busy1); end
    tick();
    tests++; if (mis1 !== 1'b0 || cyc1 !== 1'b0 || done1 !== 1'b0) begin fails++; $display("FAIL mis_half_after: mis %b cyc %b done %b want 0", mis1, cyc1, done1); end
    start_req(1'b1, 2'b10, 1'b0, 2'b10, 32'h3000_0000);
    tests++; if (mis1 !== 1'b1 || cyc1 !== 1'b0) begin fails++; $display("FAIL mis_word: mis %b cyc %b want 1 0", mis1, cyc1); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] v1, v4;
    start_req(1'b1, 2'b10, 1'b0, 2'b00, 32'h4000_0000);
    tests++; if (cyc1 !== 1'b1) begin fails++; $display("FAIL rstmid_pre: cyc %b want 1", cyc1); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (cyc1 !== 1'b0 || cyc4 !== 1'b0 || busy1 !== 1'b0) begin fails++; $display("FAIL rstmid_async: cyc %b/%b busy %b want 0", cyc1, cyc4, busy1); end
    #2 rst_n = 1'b1;
    tick();
    ack_man = 1'b1;
    tick();
    tests++; if (done1 !== 1'b0 || cyc1 !== 1'b0 || busy1 !== 1'b0) begin fails++; $display("FAIL rstmid_stray_ack: done %b cyc %b busy %b want 0", done1, cyc1, busy1); end
    tick();
    ack_man = 1'b0;
    tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL rstmid_stray_ack2: done %b want 0", done1); end
    read_out(v1, v4);
    tests++; if (v1 !== 32'h0 || v4 !== 32'h0) begin fails++; $display("FAIL rstmid_rdat: got %h/%h want 0", v1, v4); end
  endtask

  task automatic test_back_to_back();
    shift_in(32'h0BAD_F00D);
    ack_auto = 1'b1;
    req = 1'b1; we = 1'b1; size = 2'b10; sgn = 1'b0; lsb = 2'b00; adr = 32'h5000_0000;
    for (int c = 1; c <= 11; c++) begin
      tick();
      tests++;
      if (done1 !== (c % 2 == 0) || done4 !== (c % 2 == 0) || cyc1 !== ((c % 2 == 1) && (c <= 9))) begin
        fails++; $display("FAIL b2b_cycle%0d: done %b/%b cyc %b", c, done1, done4, cyc1);
      end
      if (c == 10) req = 1'b0;
    end
    req = 1'b0;
    ack_auto = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; sgn = 1'b0; size = 2'b00; lsb = 2'b00;
    adr = 32'h0; wb_rdt = 32'h0; ack_man = 1'b0; ack_auto = 1'b0;
    wen1 = 1'b0; wdat1 = 1'b0; ren1 = 1'b0; wen4 = 1'b0; wdat4 = 4'h0; ren4 = 1'b0;
    test_reset();
    test_word_store();
    test_byte_store();
    test_loads();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
